// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock, valid/ready on both sides.
// Optional build macro BIN2BCD_SAT_EN: on overflow, out_bcd saturates to all nines.
module bin_to_bcd_seq #(
  parameter int unsigned N = 14,
  parameter int unsigned K = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_bcd,
  output logic         out_ovf
);

  localparam int unsigned D     = K / 4;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       bin_q, bin_d;
  logic [K-1:0]       bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [K-1:0]       bcd_adj;
  logic [K-1:0]       bcd_shl;
  logic [N-1:0]       bin_shl;
  logic               carry_out;
  logic               last_shift;

  // Add-3 correction on every digit >= 5 before the shift, all digits in parallel.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(D); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // The bit leaving the top digit carries weight 10^D, so dropping it leaves the value mod 10^D.
  assign carry_out  = bcd_adj[K-1];
  assign bcd_shl    = {bcd_adj[K-2:0], bin_q[N-1]};
  assign bin_shl    = {bin_q[N-2:0], 1'b0};
  assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(N - 1));

  // State register and registered datapath/outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Datapath and handshake next values.
  always_comb begin
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d = in_bin;
          bcd_d = '0;
          ovf_d = 1'b0;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        bin_d = bin_shl;
        bcd_d = bcd_shl;
        ovf_d = ovf_q | carry_out;
        cnt_d = cnt_q + CNT_W'(1);
`ifdef BIN2BCD_SAT_EN
        if (last_shift && (ovf_q | carry_out)) begin
          bcd_d = K'({D{4'h9}});
        end
`else
`endif
      end
      default: begin
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bcd   = bcd_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (N=14, K=16); expectations from a decimal-digit model.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bcd;
  logic        out_ovf;

  int total = 0;
  int bad   = 0;

  bin_to_bcd_seq #(.N(14), .K(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of v mod 10^4, saturating in the SAT build.
  function automatic logic [15:0] model_bcd(input int v);
    int m;
    logic [15:0] r;
    m = v % 10000;
    r = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
`ifdef BIN2BCD_SAT_EN
    if (v > 9999) r = 16'h9999;
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [13:0] b, input string tag);
    in_bin   = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, " in_ready_after_accept"}, 32'(in_ready), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd14);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " out_valid_after_hs"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready_after_hs"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_conv(input logic [13:0] b, input logic [15:0] eb, input logic eo,
                          input string tag);
    accept(b, tag);
    wait_valid(tag);
    chk({tag, " bcd"}, 32'(out_bcd), 32'(eb));
    chk({tag, " ovf"}, 32'(out_ovf), 32'(eo));
    handshake(tag);
  endtask

  task automatic run_sweep(input int v);
    int stall;
    accept(14'(v), "sweep");
    wait_valid("sweep");
    stall = int'($urandom_range(0, 3));
    for (int s = 0; s < stall; s++) begin
      step();
      chk("sweep stall_valid", 32'(out_valid), 32'd1);
    end
    chk("sweep bcd", 32'(out_bcd), 32'(model_bcd(v)));
    chk("sweep ovf", 32'(out_ovf), 32'(v > 9999));
    for (int d = 0; d < 4; d++) begin
      chk("sweep digit_le9", 32'(out_bcd[4*d +: 4] <= 4'd9), 32'd1);
    end
    handshake("sweep");
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bin    = '0;
    out_ready = 1'b0;

    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_bcd", 32'(out_bcd), 32'd0);
    chk("reset out_ovf", 32'(out_ovf), 32'd0);
    rst = 1'b0;
    step();

    // Basic conversion.
    run_conv(14'd1234, 16'h1234, 1'b0, "t1");

    // Back-to-back: second accept lands in the IDLE cycle after the handshake.
    run_conv(14'd0, 16'h0000, 1'b0, "t2a");
    run_conv(14'd9999, 16'h9999, 1'b0, "t2b");

    // Overflow cases.
`ifdef BIN2BCD_SAT_EN
    run_conv(14'd12345, 16'h9999, 1'b1, "t3a");
    run_conv(14'd16383, 16'h9999, 1'b1, "t3b");
`else
    run_conv(14'd12345, 16'h2345, 1'b1, "t3a");
    run_conv(14'd16383, 16'h6383, 1'b1, "t3b");
`endif
    run_conv(14'd10000, model_bcd(10000), 1'b1, "t3c");

    // Backpressure with a competing in_valid that must be ignored.
    accept(14'd5678, "t4");
    wait_valid("t4");
    in_bin   = 14'd1111;
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t4 held_valid", 32'(out_valid), 32'd1);
      chk("t4 held_bcd", 32'(out_bcd), 32'h5678);
      chk("t4 in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    handshake("t4");
    step();
    chk("t4 no_second_conv", 32'(in_ready), 32'd1);

    // Asynchronous reset mid-conversion.
    accept(14'd4321, "t5");
    repeat (6) step();
    #3;
    rst = 1'b1;
    #1;
    chk("t5 async in_ready", 32'(in_ready), 32'd1);
    chk("t5 async out_valid", 32'(out_valid), 32'd0);
    chk("t5 async out_bcd", 32'(out_bcd), 32'd0);
    chk("t5 async out_ovf", 32'(out_ovf), 32'd0);
    step();
    rst  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("t5 no_emit", 32'(seen), 32'd0);
    run_conv(14'd42, 16'h0042, 1'b0, "t5b");

    // Strided sweep plus edge values with random output stalls.
    for (int v = 0; v < 16384; v += 97) run_sweep(v);
    run_sweep(9999);
    run_sweep(10000);
    run_sweep(16383);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
